// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Op encodings, FSM states and iteration constants.
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'd0,
    MDU_MULTU = 2'd1,
    MDU_DIV   = 2'd2,
    MDU_DIVU  = 2'd3
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

  localparam int ITER_COUNT = 32;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFFFFFF;

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the register-file side and the MDU.
// master drives operands and moves, slave returns HI/LO and status.
interface mul_div_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, mthi, mtlo,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_seq_core.sv
// 64-bit accumulator and radix-2 step engine (shift-add / shift-subtract).
// MDU_FAST_MUL_EN: multiplies load the full product on the load edge.
module mdu_seq_core
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic        isDiv,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  output logic [63:0] acc,
  output logic        last
);

  logic [31:0] opnd;
  logic        divR;
  logic [4:0]  cnt;
  logic [32:0] sum;
  logic [32:0] trial;
  logic [63:0] nxt;

  // one radix-2 step: multiply adds then shifts right, divide shifts left
  always_comb begin
    sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    trial = acc[63:31] - {1'b0, opnd};
    nxt   = {sum, acc[31:1]};
    if (divR) begin
      if (trial[32])
        nxt = {acc[62:0], 1'b0};
      else
        nxt = {trial[31:0], acc[30:0], 1'b1};
    end
  end

  assign last = (cnt == 5'(ITER_COUNT - 1));

  // accumulator, step operand and iteration counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      opnd <= '0;
      divR <= 1'b0;
      cnt  <= '0;
    end else if (load) begin
      divR <= isDiv;
      cnt  <= '0;
      if (isDiv) begin
        acc  <= {32'd0, opA};
        opnd <= opB;
      end else begin
`ifdef MDU_FAST_MUL_EN
        acc  <= {32'd0, opA} * {32'd0, opB};
`else
        acc  <= {32'd0, opB};
`endif
        opnd <= opA;
      end
    end else if (step) begin
      acc <= nxt;
      cnt <= cnt + 5'd1;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO pair.
// MDU_FAST_MUL_EN: single-cycle multiplies, divides stay iterative.
module mul_div_unit
  import mdu_pkg::*;
(
  input  logic clk,
  input  logic rst,
  mul_div_unit_if.slave bus
);

  mdu_state_e  state;
  logic        isSignedIn;
  logic [31:0] magA;
  logic [31:0] magB;
  logic        load;
  logic [63:0] acc;
  logic        last;
  logic        isDivR;
  logic        negRes;
  logic        negRem;
  logic        divZero;
  logic [31:0] aOrig;
  logic [31:0] hiR;
  logic [31:0] loR;
  logic        busyR;
  logic        doneR;
  logic [63:0] prod;
  logic [31:0] quot;
  logic [31:0] rem;

  assign isSignedIn = (bus.op == MDU_MULT) || (bus.op == MDU_DIV);
  assign magA = (isSignedIn && bus.a[31]) ? -bus.a : bus.a;
  assign magB = (isSignedIn && bus.b[31]) ? -bus.b : bus.b;
  assign load = (state == IDLE) && bus.start;

  mdu_seq_core core (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .step  (state == CALC),
    .isDiv (bus.op[1]),
    .opA   (magA),
    .opB   (magB),
    .acc   (acc),
    .last  (last)
  );

  assign prod = negRes ? -acc : acc;
  assign quot = negRes ? -acc[31:0] : acc[31:0];
  assign rem  = negRem ? -acc[63:32] : acc[63:32];

  // sequencing, sign bookkeeping, HI/LO writeback and handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      isDivR  <= 1'b0;
      negRes  <= 1'b0;
      negRem  <= 1'b0;
      divZero <= 1'b0;
      aOrig   <= '0;
      hiR     <= '0;
      loR     <= '0;
      busyR   <= 1'b0;
      doneR   <= 1'b0;
    end else begin
      doneR <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            isDivR  <= bus.op[1];
            negRes  <= isSignedIn & (bus.a[31] ^ bus.b[31]);
            negRem  <= isSignedIn & bus.a[31];
            divZero <= (bus.b == 32'd0);
            aOrig   <= bus.a;
`ifdef MDU_FAST_MUL_EN
            if (!bus.op[1]) begin
              state <= FIX;
            end else begin
              state <= CALC;
              busyR <= 1'b1;
            end
`else
            state <= CALC;
            busyR <= 1'b1;
`endif
          end else begin
            if (bus.mthi) hiR <= bus.a;
            if (bus.mtlo) loR <= bus.a;
          end
        end
        CALC: begin
          if (last) state <= FIX;
        end
        FIX: begin
          state <= IDLE;
          busyR <= 1'b0;
          doneR <= 1'b1;
          if (!isDivR) begin
            hiR <= prod[63:32];
            loR <= prod[31:0];
          end else if (divZero) begin
            hiR <= aOrig;
            loR <= DIV0_QUOT;
          end else begin
            hiR <= rem;
            loR <= quot;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busyR;
  assign bus.done = doneR;
  assign bus.hi   = hiR;
  assign bus.lo   = loR;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed vector bench for mul_div_unit.
// Table of ops plus hand sequences for stalls, moves, back-to-back and reset.
module tb_mul_div_unit;
  import mdu_pkg::*;

`ifdef MDU_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_div_unit_if bus ();

  mul_div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       nm;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[11];
  int nCmp = 0;
  int nBad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic startOp(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
  endtask

  task automatic waitDone(output int lat);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int expLat;
    int seen;
    logic [31:0] preHi;
    logic [31:0] preLo;

    vecs[0]  = '{"multu_ff_2",  MDU_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE};
    vecs[1]  = '{"mult_m3_5",   MDU_MULT,  32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2]  = '{"div_m7_2",    MDU_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{"div_min_m1",  MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000};
    vecs[4]  = '{"divu_100_0",  MDU_DIVU,  32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF};
    vecs[5]  = '{"div_m7_0",    MDU_DIV,   32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[6]  = '{"divu_10_3",   MDU_DIVU,  32'd10, 32'd3, 32'd1, 32'd3};
    vecs[7]  = '{"mult_7_m6",   MDU_MULT,  32'd7, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6};
    vecs[8]  = '{"multu_2p32",  MDU_MULTU, 32'h00010000, 32'h00010000, 32'd1, 32'd0};
    vecs[9]  = '{"div_7_m2",    MDU_DIV,   32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD};
    vecs[10] = '{"mult_min_sq", MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'd0};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.op = 2'd0;
    bus.a = '0;
    bus.b = '0;
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    #2;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // moves
    @(negedge clk);
    bus.mtlo = 1'b1;
    bus.a = 32'h1234;
    @(posedge clk);
    #1;
    bus.mtlo = 1'b0;
    chk("mtlo_lo", bus.lo, 32'h1234);
    chk("mtlo_hi", bus.hi, 32'd0);
    @(negedge clk);
    bus.mthi = 1'b1;
    bus.a = 32'hCAFE0001;
    @(posedge clk);
    #1;
    bus.mthi = 1'b0;
    chk("mthi_hi", bus.hi, 32'hCAFE0001);
    chk("mthi_lo", bus.lo, 32'h1234);

    // table
    for (int i = 0; i < 11; i++) begin
      expLat = (FAST && !vecs[i].op[1]) ? 1 : 33;
      startOp(vecs[i].op, vecs[i].a, vecs[i].b);
      chk({vecs[i].nm, "_busy"}, 32'(bus.busy), 32'(expLat != 1));
      waitDone(lat);
      chk({vecs[i].nm, "_lat"}, 32'(lat), 32'(expLat));
      chk({vecs[i].nm, "_hi"}, bus.hi, vecs[i].hi);
      chk({vecs[i].nm, "_lo"}, bus.lo, vecs[i].lo);
      chk({vecs[i].nm, "_busyDone"}, 32'(bus.busy), 32'd0);
      @(posedge clk);
      #1;
      chk({vecs[i].nm, "_pulse"}, 32'(bus.done), 32'd0);
    end

    // start and mthi while busy are ignored; HI/LO stable during CALC
    preHi = bus.hi;
    preLo = bus.lo;
    startOp(MDU_DIVU, 32'd10, 32'd3);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      bus.start = (k == 5);
      bus.mthi = (k == 6);
      if (k == 5 || k == 6) begin
        bus.a = 32'd1;
        bus.b = 32'd1;
      end
      @(posedge clk);
      #1;
      if (k == 7) begin
        chk("stall_hi", bus.hi, preHi);
        chk("stall_lo", bus.lo, preLo);
      end
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    bus.start = 1'b0;
    bus.mthi = 1'b0;
    chk("stall_lat", 32'(lat), 32'd33);
    chk("stall_hi_res", bus.hi, 32'd1);
    chk("stall_lo_res", bus.lo, 32'd3);

    // back-to-back start in the done cycle
    bus.start = 1'b1;
    bus.op = MDU_DIVU;
    bus.a = 32'd9;
    bus.b = 32'd2;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("b2b_busy", 32'(bus.busy), 32'd1);
    waitDone(lat);
    chk("b2b_lat", 32'(lat), 32'd33);
    chk("b2b_hi", bus.hi, 32'd1);
    chk("b2b_lo", bus.lo, 32'd4);

    // start beats simultaneous moves
    preHi = bus.hi;
    preLo = bus.lo;
    @(negedge clk);
    bus.start = 1'b1;
    bus.mthi = 1'b1;
    bus.mtlo = 1'b1;
    bus.op = MDU_DIVU;
    bus.a = 32'd50;
    bus.b = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    chk("mv_drop_hi", bus.hi, preHi);
    chk("mv_drop_lo", bus.lo, preLo);
    waitDone(lat);
    chk("mv_drop_lat", 32'(lat), 32'd33);
    chk("mv_res_hi", bus.hi, 32'd1);
    chk("mv_res_lo", bus.lo, 32'd7);

    // reset mid-operation
    startOp(MDU_DIVU, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_hi", bus.hi, 32'd0);
    chk("mid_rst_lo", bus.lo, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) seen++;
    end
    chk("mid_rst_quiet", 32'(seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
